// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - two-requester round-robin arbiter sharing one registered bitwise logic unit
// Optional feature macro: LOGIC_ARB_ZERO_FLAG_EN adds a registered rsp_zero flag.
module logic_unit_arbiter #(
    parameter int LENGTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [LENGTH-1:0] req0_x,
    input  logic [LENGTH-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [LENGTH-1:0] req1_x,
    input  logic [LENGTH-1:0] req1_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    output logic              rsp_zero,
`endif
    output logic [LENGTH-1:0] rsp_z
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_grant_q;
    logic              grant;
    logic              can_accept;
    logic              accept;
    logic [1:0]        sel_op;
    logic [LENGTH-1:0] sel_x;
    logic [LENGTH-1:0] sel_y;
    logic [LENGTH-1:0] result;

    function automatic logic [LENGTH-1:0] bitop(input logic [1:0] op,
                                                input logic [LENGTH-1:0] x,
                                                input logic [LENGTH-1:0] y);
        case (op)
            2'b00:   bitop = x & y;
            2'b01:   bitop = x | y;
            2'b10:   bitop = x ^ y;
            default: bitop = ~(x | y);
        endcase
    endfunction

    // Grant only moves after a handshake because last_grant_q only updates on accept.
    always_comb begin
        grant      = ~last_grant_q;
        can_accept = (state_q == EMPTY) | rsp_ready;
        if (req0_valid & ~req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid & ~req0_valid) begin
            grant = 1'b1;
        end
        req0_ready = can_accept & ~grant & ~rst;
        req1_ready = can_accept & grant & ~rst;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        sel_op     = grant ? req1_op : req0_op;
        sel_x      = grant ? req1_x  : req0_x;
        sel_y      = grant ? req1_y  : req0_y;
        result     = bitop(sel_op, sel_x, sel_y);
        state_d    = state_q;
        if (accept) begin
            state_d = FULL;
        end else if (rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            rsp_z        <= '0;
            rsp_id       <= 1'b0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            rsp_zero     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_z        <= result;
                rsp_id       <= grant;
                last_grant_q <= grant;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                rsp_zero     <= (result == '0);
`endif
            end
        end
    end

    assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - scoreboard bench for logic_unit_arbiter (optional LOGIC_ARB_ZERO_FLAG_EN)
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_z;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic        rsp_zero;
`endif

    always #5 clk = ~clk;

    logic_unit_arbiter #(.LENGTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        .rsp_zero(rsp_zero),
`endif
        .rsp_z(rsp_z)
    );

    typedef struct {
        logic        id;
        logic [31:0] z;
        logic        zero;
    } rsp_t;

    rsp_t q[$];
    bit   m_last  = 1'b1;
    bit   m_full  = 1'b0;
    bit   m_fresh = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // -1 = nobody asking; otherwise the requester the rules say must win
    function automatic int winner(input logic v0, input logic v1, input bit last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (v0 && v1)  return last ? 0 : 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Predictor: reference model advanced at each clock edge from the inputs alone.
    always @(posedge clk) begin
        int   w;
        rsp_t r;
        if (rst) begin
            q.delete();
            m_last  = 1'b1;
            m_full  = 1'b0;
            m_fresh = 1'b1;
        end else begin
            w = winner(req0_valid, req1_valid, m_last);
            if (w >= 0 && (!m_full || rsp_ready)) begin
                r.id   = (w == 1);
                r.z    = (w == 1) ? ref_op(req1_op, req1_x, req1_y) : ref_op(req0_op, req0_x, req0_y);
                r.zero = (r.z == 32'd0);
                q.push_back(r);
                m_last  = (w == 1);
                m_full  = 1'b1;
                m_fresh = 1'b0;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compares readys and the presented response on the falling edge.
    always @(negedge clk) begin
        int w;
        if (rst) begin
            chk("ready0_in_rst", {31'd0, req0_ready}, 32'd0);
            chk("ready1_in_rst", {31'd0, req1_ready}, 32'd0);
        end else begin
            w = winner(req0_valid, req1_valid, m_last);
            if (w >= 0) begin
                chk("ready0", {31'd0, req0_ready}, {31'd0, ((!m_full || rsp_ready) && w == 0)});
                chk("ready1", {31'd0, req1_ready}, {31'd0, ((!m_full || rsp_ready) && w == 1)});
            end else begin
                chk("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            end
        end
        if (q.size() == 0) begin
            chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
            if (m_fresh) begin
                chk("rsp_z_reset", rsp_z, 32'd0);
                chk("rsp_id_reset", {31'd0, rsp_id}, 32'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                chk("rsp_zero_reset", {31'd0, rsp_zero}, 32'd0);
`endif
            end
        end else begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
            chk("rsp_z", rsp_z, q[0].z);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, q[0].zero});
`endif
            if (rsp_ready) void'(q.pop_front());
        end
    end

    bit h0, h1;

    task automatic tick();
        @(negedge clk);
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        req0_valid = v; req0_op = op; req0_x = x; req0_y = y;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        req1_valid = v; req1_op = op; req1_x = x; req1_y = y;
    endtask

    initial begin
        logic [31:0] rx;
        rst = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        set1(1'b0, 2'd0, 32'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // single requester OR
        set0(1'b1, 2'd1, 32'hF0F0_0000, 32'h0000_0F0F);
        tick();
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        tick();

        // contention with full throughput
        set0(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set1(1'b1, 2'd2, 32'hAAAA_AAAA, 32'h5555_5555);
        repeat (8) tick();
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        set1(1'b0, 2'd0, 32'd0, 32'd0);
        tick();

        // NOR then backpressure, pending req1 accepted on release
        set0(1'b1, 2'd3, 32'd0, 32'd0);
        tick();
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        set1(1'b1, 2'd1, 32'h1234_0000, 32'h0000_5678);
        rsp_ready = 1'b0;
        repeat (3) tick();
        rsp_ready = 1'b1;
        tick();
        set1(1'b0, 2'd0, 32'd0, 32'd0);
        tick();

        // reset while a result is held; next contention must go to req0
        set1(1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        tick();
        set1(1'b0, 2'd0, 32'd0, 32'd0);
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        set0(1'b1, 2'd2, 32'h0000_00FF, 32'h0000_0F0F);
        set1(1'b1, 2'd0, 32'hFFFF_0000, 32'hFF00_FF00);
        repeat (2) tick();
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        set1(1'b0, 2'd0, 32'd0, 32'd0);
        tick();

        // zero-result AND, then nonzero OR on the same operands
        set0(1'b1, 2'd0, 32'h0000_FFFF, 32'hFFFF_0000);
        tick();
        set0(1'b1, 2'd1, 32'h0000_FFFF, 32'hFFFF_0000);
        tick();
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        tick();

        // randomized traffic honouring hold-until-ready
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid || h0) begin
                rx = $urandom;
                set0(($urandom % 3) != 0, 2'($urandom % 4), rx, ($urandom % 4 == 0) ? ~rx : $urandom);
            end
            if (!req1_valid || h1) begin
                rx = $urandom;
                set1(($urandom % 3) != 0, 2'($urandom % 4), rx, ($urandom % 4 == 0) ? rx : $urandom);
            end
            rsp_ready = ($urandom % 4) != 0;
            rst = ($urandom % 250) == 0;
            tick();
        end
        rst = 1'b0;
        set0(1'b0, 2'd0, 32'd0, 32'd0);
        set1(1'b0, 2'd0, 32'd0, 32'd0);
        rsp_ready = 1'b1;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
